// File: rtl/eflags_reg_unit_pkg.sv
// Shared EFLAGS definitions: bit positions, size/op encodings, mask order, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package eflags_reg_unit_pkg;

    // Architectural bit positions inside the 32-bit register
    localparam int OF_BIT = 11;
    localparam int DF_BIT = 10;
    localparam int SF_BIT = 7;
    localparam int ZF_BIT = 6;
    localparam int AF_BIT = 4;
    localparam int PF_BIT = 2;
    localparam int CF_BIT = 0;

    // Bits that physically exist; everything else reads as zero
    localparam logic [31:0] FLAGS_IMPL = 32'h0000_0CD5;

    // wb_size encodings (2'b11 behaves like 32-bit)
    localparam logic [1:0] SZ_8  = 2'b00;
    localparam logic [1:0] SZ_16 = 2'b01;
    localparam logic [1:0] SZ_32 = 2'b10;

    // wb_op encodings; unlisted values are no-ops
    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_LOGIC = 3'd2;
    localparam logic [2:0] OP_LOAD  = 3'd3;
    localparam logic [2:0] OP_CMC   = 3'd4;
    localparam logic [2:0] OP_SETDF = 3'd5;
    localparam logic [2:0] OP_CLRDF = 3'd6;

    // Mask / candidate vector order {OF,DF,SF,ZF,AF,PF,CF}
    localparam int M_OF = 6;
    localparam int M_DF = 5;
    localparam int M_SF = 4;
    localparam int M_ZF = 3;
    localparam int M_AF = 2;
    localparam int M_PF = 1;
    localparam int M_CF = 0;

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_FULL} state_e;

    // Replace each enabled flag of cur with its candidate value
    function automatic logic [31:0] apply_mask(input logic [31:0] cur,
                                               input logic [6:0]  cand,
                                               input logic [6:0]  en);
        logic [31:0] r;
        r = cur;
        if (en[M_OF]) r[OF_BIT] = cand[M_OF];
        if (en[M_DF]) r[DF_BIT] = cand[M_DF];
        if (en[M_SF]) r[SF_BIT] = cand[M_SF];
        if (en[M_ZF]) r[ZF_BIT] = cand[M_ZF];
        if (en[M_AF]) r[AF_BIT] = cand[M_AF];
        if (en[M_PF]) r[PF_BIT] = cand[M_PF];
        if (en[M_CF]) r[CF_BIT] = cand[M_CF];
        return r;
    endfunction

endpackage

// File: rtl/eflags_reg_unit_if.sv
// Bundle between decode/writeback and the EFLAGS unit.
// Latency: n/a (wires only).
// Backpressure: alloc uses alloc_ready; writeback is always accepted.
interface eflags_reg_unit_if #(parameter int DATA_W = 32);
    logic              alloc_valid;
    logic              alloc_ready;
    logic              wb_valid;
    logic [1:0]        wb_size;
    logic [2:0]        wb_op;
    logic [DATA_W-1:0] wb_a;
    logic [DATA_W-1:0] wb_b;
    logic [DATA_W-1:0] wb_result;
    logic              wb_cf;
    logic              wb_af;
    logic [6:0]        wb_mask;
    logic              squash;
    logic [31:0]       flags;
    logic [31:0]       flags_fwd;
    logic              flags_busy;
    logic              pend_err;

    modport master (
        output alloc_valid, wb_valid, wb_size, wb_op, wb_a, wb_b, wb_result,
               wb_cf, wb_af, wb_mask, squash,
        input  alloc_ready, flags, flags_fwd, flags_busy, pend_err
    );

    modport slave (
        input  alloc_valid, wb_valid, wb_size, wb_op, wb_a, wb_b, wb_result,
               wb_cf, wb_af, wb_mask, squash,
        output alloc_ready, flags, flags_fwd, flags_busy, pend_err
    );
endinterface

// File: rtl/eflags_reg_unit_compute.sv
// Next-EFLAGS calculator from a writeback and the current flags (also used by decode predictor).
// Latency: combinational.
// Backpressure: none.
module eflags_reg_unit_compute
    import eflags_reg_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [31:0]       i_flags,
    input  logic              i_wb_valid,
    input  logic [1:0]        i_size,
    input  logic [2:0]        i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [DATA_W-1:0] i_result,
    input  logic              i_cf,
    input  logic              i_af,
    input  logic [6:0]        i_mask,
    output logic [31:0]       o_flags_nxt
);
    logic        w_a_m;
    logic        w_b_m;
    logic        w_r_m;
    logic        w_zf;
    logic        w_pf;
    logic [6:0]  w_cand;
    logic [31:0] w_nxt;
    logic        w_unused;

    // Operand bits not selected by the size only feed the sign/zero pickers
    assign w_unused = ^{i_a, i_b};

    assign w_pf = ~^i_result[7:0];

    // Pick sign bits and zero test at the selected operand size
    always_comb begin
        w_a_m = i_a[31];
        w_b_m = i_b[31];
        w_r_m = i_result[31];
        w_zf  = ~|i_result[31:0];
        case (i_size)
            SZ_8: begin
                w_a_m = i_a[7];
                w_b_m = i_b[7];
                w_r_m = i_result[7];
                w_zf  = ~|i_result[7:0];
            end
            SZ_16: begin
                w_a_m = i_a[15];
                w_b_m = i_b[15];
                w_r_m = i_result[15];
                w_zf  = ~|i_result[15:0];
            end
            default: ;
        endcase
    end

    // Build candidate flags per op and merge through the write mask
    always_comb begin
        w_cand = '0;
        w_nxt  = i_flags;
        case (i_op)
            OP_ADD, OP_SUB, OP_LOGIC: begin
                w_cand[M_SF] = w_r_m;
                w_cand[M_ZF] = w_zf;
                w_cand[M_PF] = w_pf;
                if (i_op == OP_ADD) begin
                    w_cand[M_OF] = (w_a_m == w_b_m) & (w_r_m != w_a_m);
                    w_cand[M_AF] = i_af;
                    w_cand[M_CF] = i_cf;
                end else if (i_op == OP_SUB) begin
                    w_cand[M_OF] = (w_a_m != w_b_m) & (w_r_m != w_a_m);
                    w_cand[M_AF] = i_af;
                    w_cand[M_CF] = i_cf;
                end
                // DF is never written by arithmetic/logic results
                w_nxt = apply_mask(i_flags, w_cand, i_mask & 7'b101_1111);
            end
            OP_LOAD: begin
                w_cand = {i_result[OF_BIT], i_result[DF_BIT], i_result[SF_BIT],
                          i_result[ZF_BIT], i_result[AF_BIT], i_result[PF_BIT],
                          i_result[CF_BIT]};
                w_nxt  = apply_mask(i_flags, w_cand, i_mask);
            end
            OP_CMC:   w_nxt[CF_BIT] = ~i_flags[CF_BIT];
            OP_SETDF: w_nxt[DF_BIT] = 1'b1;
            OP_CLRDF: w_nxt[DF_BIT] = 1'b0;
            default:  ;
        endcase
        if (!i_wb_valid) begin
            w_nxt = i_flags;
        end
    end

    assign o_flags_nxt = w_nxt & FLAGS_IMPL;

endmodule

// File: rtl/eflags_reg_unit.sv
// Architectural EFLAGS register with in-flight flag-writer tracking.
// Latency: flags update on the edge after wb_valid; flags_fwd bypasses the same cycle.
// Backpressure: alloc_ready drops when MAX_INFLIGHT writers are pending; writeback never stalls.
module eflags_reg_unit
    import eflags_reg_unit_pkg::*;
#(
    parameter int          DATA_W       = 32,
    parameter int          MAX_INFLIGHT = 4,
    parameter logic [31:0] RESET_FLAGS  = 32'h0
) (
    input logic               i_clk,
    input logic               i_rst_n,
    eflags_reg_unit_if.slave  bus
);
    localparam int                CNT_W   = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_INFLIGHT);

    logic [31:0]      r_flags;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
    state_e           r_state;

    logic [31:0]      w_flags_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_err_set;
    logic             w_inc;
    logic             w_dec;
    logic             w_ready;
    state_e           w_state_nxt;

    eflags_reg_unit_compute #(.DATA_W(DATA_W)) u_compute (
        .i_flags     (r_flags),
        .i_wb_valid  (bus.wb_valid),
        .i_size      (bus.wb_size),
        .i_op        (bus.wb_op),
        .i_a         (bus.wb_a),
        .i_b         (bus.wb_b),
        .i_result    (bus.wb_result),
        .i_cf        (bus.wb_cf),
        .i_af        (bus.wb_af),
        .i_mask      (bus.wb_mask),
        .o_flags_nxt (w_flags_nxt)
    );

    assign w_ready = (r_state != ST_FULL);
    assign w_inc   = bus.alloc_valid & w_ready & ~bus.squash;
    assign w_dec   = bus.wb_valid;

    // Pending-writer count update; squash wins and suppresses underflow errors
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_err_set = 1'b0;
        if (bus.squash) begin
            w_cnt_nxt = '0;
        end else if (w_inc && !w_dec) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end else if (!w_inc && w_dec) begin
            if (r_cnt == '0) begin
                w_err_set = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
            end
        end
    end

    // Occupancy state follows the next count value
    always_comb begin
        w_state_nxt = ST_BUSY;
        if (bus.squash || w_cnt_nxt == '0) begin
            w_state_nxt = ST_IDLE;
        end else if (w_cnt_nxt == CNT_MAX) begin
            w_state_nxt = ST_FULL;
        end
    end

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Flags, pending count and sticky protocol error
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_flags <= RESET_FLAGS & FLAGS_IMPL;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_flags <= w_flags_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= r_err | w_err_set;
        end
    end

    assign bus.alloc_ready = w_ready;
    assign bus.flags_busy  = (r_state != ST_IDLE);
    assign bus.flags       = r_flags;
    assign bus.flags_fwd   = w_flags_nxt;
    assign bus.pend_err    = r_err;

endmodule

// File: tb/tb_eflags_reg_unit.sv
// Directed bench for eflags_reg_unit with hand-computed expectations.
// Latency: n/a.
// Backpressure: n/a.
module tb_eflags_reg_unit;
    import eflags_reg_unit_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    eflags_reg_unit_if #(.DATA_W(32)) bus ();

    eflags_reg_unit #(
        .DATA_W       (32),
        .MAX_INFLIGHT (4),
        .RESET_FLAGS  (32'h0)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clr;
        bus.alloc_valid = 1'b0;
        bus.wb_valid    = 1'b0;
        bus.wb_size     = SZ_32;
        bus.wb_op       = OP_LOGIC;
        bus.wb_a        = '0;
        bus.wb_b        = '0;
        bus.wb_result   = '0;
        bus.wb_cf       = 1'b0;
        bus.wb_af       = 1'b0;
        bus.wb_mask     = '0;
        bus.squash      = 1'b0;
    endtask

    task automatic wb(input logic [1:0] sz, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] r, input logic cf,
                      input logic af, input logic [6:0] m);
        bus.wb_valid  = 1'b1;
        bus.wb_size   = sz;
        bus.wb_op     = op;
        bus.wb_a      = a;
        bus.wb_b      = b;
        bus.wb_result = r;
        bus.wb_cf     = cf;
        bus.wb_af     = af;
        bus.wb_mask   = m;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clr();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_flags", bus.flags, 32'h0);
        check("rst_busy", {31'b0, bus.flags_busy}, 32'd0);
        check("rst_ready", {31'b0, bus.alloc_ready}, 32'd1);
        check("rst_err", {31'b0, bus.pend_err}, 32'd0);

        // Two writers, then a full-image LOAD (unimplemented bits must stay 0)
        bus.alloc_valid = 1'b1;
        tick();
        tick();
        bus.alloc_valid = 1'b0;
        check("alloc2_busy", {31'b0, bus.flags_busy}, 32'd1);
        wb(SZ_32, OP_LOAD, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0, 7'h7F);
        #1;
        check("load_fwd", bus.flags_fwd, 32'h0000_0CD5);
        check("load_hold", bus.flags, 32'h0);
        tick();
        clr();
        check("load_flags", bus.flags, 32'h0000_0CD5);

        // Reset mid-activity with alloc and writeback both active
        rst_n = 1'b0;
        bus.alloc_valid = 1'b1;
        wb(SZ_32, OP_LOAD, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0, 7'h7F);
        tick();
        tick();
        rst_n = 1'b1;
        clr();
        check("mid_rst_flags", bus.flags, 32'h0);
        check("mid_rst_busy", {31'b0, bus.flags_busy}, 32'd0);
        check("mid_rst_ready", {31'b0, bus.alloc_ready}, 32'd1);
        check("mid_rst_err", {31'b0, bus.pend_err}, 32'd0);

        // ADD 8b overflow: 7F + 01 = 80
        bus.alloc_valid = 1'b1;
        tick();
        bus.alloc_valid = 1'b0;
        wb(SZ_8, OP_ADD, 32'h7F, 32'h01, 32'h80, 1'b0, 1'b1, 7'h5F);
        #1;
        check("add8_fwd", bus.flags_fwd, 32'h0000_0890);
        tick();
        clr();
        check("add8_flags", bus.flags, 32'h0000_0890);
        check("add8_busy", {31'b0, bus.flags_busy}, 32'd0);
        check("add8_err", {31'b0, bus.pend_err}, 32'd0);
        #1;
        check("fwd_idle", bus.flags_fwd, 32'h0000_0890);

        // SUB 16b 0 - 1 = FFFF, upper result bits set; alloc+wb at count 0
        bus.alloc_valid = 1'b1;
        wb(SZ_16, OP_SUB, 32'h0, 32'h1, 32'hFFFF_FFFF, 1'b1, 1'b1, 7'h5F);
        tick();
        clr();
        check("sub16_flags", bus.flags, 32'h0000_0095);
        check("sub16_err", {31'b0, bus.pend_err}, 32'd0);

        // LOGIC 8b: upper result bits ignored for ZF; only SF/ZF enabled
        bus.alloc_valid = 1'b1;
        wb(SZ_8, OP_LOGIC, 32'h0, 32'h0, 32'hFFFF_FF00, 1'b1, 1'b1, 7'h18);
        tick();
        clr();
        check("logic8_flags", bus.flags, 32'h0000_0055);

        bus.alloc_valid = 1'b1;
        wb(SZ_32, OP_SETDF, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 7'h00);
        tick();
        clr();
        check("setdf_flags", bus.flags, 32'h0000_0455);

        // LOGIC 32b zero result, all mask bits: DF must survive
        bus.alloc_valid = 1'b1;
        wb(SZ_32, OP_LOGIC, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 7'h7F);
        tick();
        clr();
        check("logic32_flags", bus.flags, 32'h0000_0444);

        bus.alloc_valid = 1'b1;
        wb(SZ_32, OP_CMC, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 7'h00);
        tick();
        clr();
        check("cmc_flags", bus.flags, 32'h0000_0445);

        bus.alloc_valid = 1'b1;
        wb(SZ_32, OP_CLRDF, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 7'h7F);
        tick();
        clr();
        check("clrdf_flags", bus.flags, 32'h0000_0045);

        bus.alloc_valid = 1'b1;
        wb(SZ_32, OP_LOAD, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 7'h01);
        tick();
        clr();
        check("load_cf_only", bus.flags, 32'h0000_0044);
        check("pairs_busy", {31'b0, bus.flags_busy}, 32'd0);

        // Five allocs: fifth is dropped
        bus.alloc_valid = 1'b1;
        repeat (5) tick();
        bus.alloc_valid = 1'b0;
        check("full_ready", {31'b0, bus.alloc_ready}, 32'd0);
        check("full_busy", {31'b0, bus.flags_busy}, 32'd1);
        wb(SZ_32, OP_LOGIC, 32'h0, 32'h0, 32'h1, 1'b0, 1'b0, 7'h00);
        tick();
        check("cnt3_ready", {31'b0, bus.alloc_ready}, 32'd1);
        bus.alloc_valid = 1'b1;
        tick();
        check("cnt3_pair_ready", {31'b0, bus.alloc_ready}, 32'd1);
        clr();
        bus.alloc_valid = 1'b1;
        tick();
        clr();
        check("cnt4_ready", {31'b0, bus.alloc_ready}, 32'd0);
        wb(SZ_32, OP_LOGIC, 32'h0, 32'h0, 32'h1, 1'b0, 1'b0, 7'h00);
        repeat (3) tick();
        check("cnt1_busy", {31'b0, bus.flags_busy}, 32'd1);
        tick();
        clr();
        check("drain_busy", {31'b0, bus.flags_busy}, 32'd0);
        check("drain_err", {31'b0, bus.pend_err}, 32'd0);
        check("drain_flags", bus.flags, 32'h0000_0044);

        // Writeback with nothing pending: commits, sets sticky error
        wb(SZ_32, OP_LOAD, 32'h0, 32'h0, 32'h1, 1'b0, 1'b0, 7'h01);
        tick();
        clr();
        check("orphan_flags", bus.flags, 32'h0000_0045);
        check("orphan_err", {31'b0, bus.pend_err}, 32'd1);
        check("orphan_busy", {31'b0, bus.flags_busy}, 32'd0);
        tick();
        check("err_sticky", {31'b0, bus.pend_err}, 32'd1);

        // Squash with three pending plus wb and alloc in the same cycle
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        bus.alloc_valid = 1'b1;
        repeat (3) tick();
        check("pre_squash_ready", {31'b0, bus.alloc_ready}, 32'd1);
        bus.squash = 1'b1;
        wb(SZ_32, OP_LOAD, 32'h0, 32'h0, 32'h0000_0801, 1'b0, 1'b0, 7'h7F);
        tick();
        clr();
        check("squash_flags", bus.flags, 32'h0000_0801);
        check("squash_busy", {31'b0, bus.flags_busy}, 32'd0);
        check("squash_ready", {31'b0, bus.alloc_ready}, 32'd1);
        check("squash_err", {31'b0, bus.pend_err}, 32'd0);
        wb(SZ_32, OP_LOAD, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 7'h00);
        tick();
        clr();
        check("post_squash_err", {31'b0, bus.pend_err}, 32'd1);
        check("post_squash_flags", bus.flags, 32'h0000_0801);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
